// File: rtl/dm_responder.sv
// Multi-cycle data memory for the load/store port. Requests use a req/ack handshake,
// and the ack comes after a programmable number of wait cycles.
module dm_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata
);

  localparam int         DEPTH     = 1 << (ADDR_W - 2);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                wr_r, sext_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [1:0]          size_r;

  logic                wr_s, sext_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [31:0]         wdata_s;
  logic [1:0]          size_s;
  logic [ADDR_W-3:0]   word_idx_s;
  logic                commit_s, err_s, mem_we_s;
  logic [3:0]          be_s;
  logic [31:0]         wword_s, rd_word_s;

  logic                busy_r, ack_r, err_r;
  logic [31:0]         rdata_r;
  logic [31:0]         mem_r [DEPTH];

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic bad_s;
    case (sz)
      2'd0:    bad_s = 1'b0;
      2'd1:    bad_s = lo[0];
      2'd2:    bad_s = (lo != 2'd0);
      default: bad_s = 1'b1;
    endcase
    return bad_s;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << lo;
      2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lo, input logic sx);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {lo, 3'b000};
    case (sz)
      2'd0:    res = {{24{sx & shifted[7]}}, shifted[7:0]};
      2'd1:    res = {{16{sx & shifted[15]}}, shifted[15:0]};
      2'd2:    res = shifted;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // In IDLE the live request fields are used so a zero-wait access can commit on its accept edge.
  always_comb begin
    if (state_r == S_IDLE) begin
      wr_s    = wr;
      addr_s  = addr;
      wdata_s = wdata;
      size_s  = size;
      sext_s  = sext;
    end else begin
      wr_s    = wr_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      size_s  = size_r;
      sext_s  = sext_r;
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          state_s = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
          cnt_s   = WAIT_LOAD;
        end else begin
          state_s = S_IDLE;
          cnt_s   = cnt_r;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = S_DONE;
          cnt_s   = cnt_r;
        end else begin
          state_s = S_WAIT;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Access decode; DONE is only ever entered from IDLE or WAIT, so this marks the commit edge.
  always_comb begin
    word_idx_s = addr_s[ADDR_W-1:2];
    commit_s   = (state_s == S_DONE);
    err_s      = misaligned(size_s, addr_s[1:0]);
    be_s       = lane_enables(size_s, addr_s[1:0]);
    wword_s    = wdata_s << {addr_s[1:0], 3'b000};
    mem_we_s   = commit_s & wr_s & ~err_s;
    rd_word_s  = mem_r[word_idx_s];
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      wr_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      size_r  <= 2'd0;
      sext_r  <= 1'b0;
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (state_r == S_IDLE && req) begin
        wr_r    <= wr;
        addr_r  <= addr;
        wdata_r <= wdata;
        size_r  <= size;
        sext_r  <= sext;
      end
      busy_r <= (state_s != S_IDLE);
      ack_r  <= commit_s;
      err_r  <= commit_s & err_s;
      if (commit_s && !wr_s && !err_s) begin
        rdata_r <= extract_load(rd_word_s, size_s, addr_s[1:0], sext_s);
      end else begin
        rdata_r <= 32'd0;
      end
    end
  end

  // Storage is never cleared; reset only blocks a write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wword_s[8*i +: 8];
        end
      end
    end
  end

  assign busy  = busy_r;
  assign ack   = ack_r;
  assign err   = err_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a transaction-level byte-memory model checked every cycle,
// plus directed accesses with hand-computed results on a 2-wait and a 0-wait instance.
module tb_dm_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req[2], wr[2], sext[2];
  logic [11:0] addr[2];
  logic [31:0] wdata[2];
  logic [1:0]  size[2];
  logic        busy[2], ack[2], err[2];
  logic [31:0] rdata[2];

  dm_responder #(.WAIT_CYCLES(2), .ADDR_W(12)) dut_w2 (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .size(size[0]), .sext(sext[0]), .busy(busy[0]), .ack(ack[0]), .err(err[0]), .rdata(rdata[0])
  );

  dm_responder #(.WAIT_CYCLES(0), .ADDR_W(12)) dut_w0 (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .size(size[1]), .sext(sext[1]), .busy(busy[1]), .ack(ack[1]), .err(err[1]), .rdata(rdata[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mb[2][4096];
  int          k_m[2];
  bit          pend[2];
  int          acc_e[2], ack_e[2];
  bit          p_wr[2], p_err[2];
  logic [11:0] p_addr[2];
  logic [31:0] p_wdata[2], p_rdata[2];
  logic [1:0]  p_size[2];
  logic        exp_busy[2], exp_ack[2], exp_err[2];
  logic [31:0] exp_rdata[2];
  bit          model_on = 1'b0;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic commit(input int d);
    int n;
    n = nbytes(p_size[d]);
    if (p_wr[d] && !p_err[d])
      for (int i = 0; i < n; i++)
        mb[d][(int'(p_addr[d]) + i) & 4095] = 8'((p_wdata[d] >> (8 * i)) & 32'hFF);
  endtask

  task automatic model_step(input int d);
    bit     idle_before, in_op;
    int     n;
    longint v;
    k_m[d]++;
    if (rst) begin
      pend[d] = 1'b0;
    end else begin
      if (pend[d] && k_m[d] == ack_e[d]) commit(d);
      idle_before = !(pend[d] && (k_m[d] - 1) >= acc_e[d] && (k_m[d] - 1) <= ack_e[d]);
      if (idle_before && req[d]) begin
        pend[d]    = 1'b1;
        acc_e[d]   = k_m[d];
        ack_e[d]   = k_m[d] + wait_of(d);
        p_wr[d]    = wr[d];
        p_addr[d]  = addr[d];
        p_wdata[d] = wdata[d];
        p_size[d]  = size[d];
        p_err[d]   = (size[d] == 2'd3) || (size[d] == 2'd1 && addr[d] % 2 != 0) ||
                     (size[d] == 2'd2 && addr[d] % 4 != 0);
        p_rdata[d] = 32'd0;
        if (!wr[d] && !p_err[d]) begin
          n = nbytes(size[d]);
          v = 0;
          for (int i = 0; i < n; i++)
            v = v | (longint'(mb[d][(int'(addr[d]) + i) & 4095]) << (8 * i));
          if (sext[d] && ((v >> (8 * n - 1)) & 1) == 1)
            v = v | ~((longint'(1) << (8 * n)) - 1);
          p_rdata[d] = 32'(v);
        end
        if (k_m[d] == ack_e[d]) commit(d);
      end
    end
    in_op        = pend[d] && k_m[d] >= acc_e[d] && k_m[d] <= ack_e[d];
    exp_busy[d]  = in_op;
    exp_ack[d]   = in_op && (k_m[d] == ack_e[d]);
    exp_err[d]   = exp_ack[d] && p_err[d];
    exp_rdata[d] = exp_ack[d] ? p_rdata[d] : 32'd0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      if (rst) model_on = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        for (int d = 0; d < 2; d++) begin
          check($sformatf("d%0d_busy", d),  busy[d],  exp_busy[d]);
          check($sformatf("d%0d_ack", d),   ack[d],   exp_ack[d]);
          check($sformatf("d%0d_err", d),   err[d],   exp_err[d]);
          check($sformatf("d%0d_rdata", d), rdata[d], exp_rdata[d]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_access(input int d, input bit w, input logic [11:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input bit sx,
                           output logic [31:0] rd, output logic e, output int lat);
    bit got;
    @(negedge clk);
    wr[d] = w; addr[d] = a; wdata[d] = wd; size[d] = sz; sext[d] = sx; req[d] = 1'b1;
    got = 1'b0; lat = 0; rd = 32'd0; e = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack[d]) begin
        got = 1'b1;
        rd  = rdata[d];
        e   = err[d];
      end
    end
    req[d] = 1'b0;
    check("ack_seen", {31'd0, got}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  logic [3:0]  ackbits, busybits;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 12'd0; wdata[d] = 32'd0; size[d] = 2'd0; sext[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy[0], 1'b0);
    check("rst_ack", ack[0], 1'b0);
    check("rst_err", err[0], 1'b0);
    check("rst_rdata", rdata[0], 32'd0);
    rst = 1'b0;

    // seed the locations used below
    do_access(0, 1'b1, 12'h020, 32'h0000_0000, 2'd2, 1'b0, rd, e, lat);
    do_access(0, 1'b1, 12'h030, 32'h1357_9BDF, 2'd2, 1'b0, rd, e, lat);

    do_access(0, 1'b1, 12'h010, 32'hDEAD_BEEF, 2'd2, 1'b0, rd, e, lat);
    check("st_word_lat", lat, 32'd3);
    check("st_word_err", e, 1'b0);
    check("st_word_rdata", rd, 32'd0);
    do_access(0, 1'b0, 12'h010, 32'd0, 2'd2, 1'b0, rd, e, lat);
    check("ld_word_lat", lat, 32'd3);
    check("ld_word", rd, 32'hDEAD_BEEF);

    do_access(0, 1'b1, 12'h013, 32'h0000_0080, 2'd0, 1'b0, rd, e, lat);
    do_access(0, 1'b0, 12'h013, 32'd0, 2'd0, 1'b1, rd, e, lat);
    check("ld_byte_sext", rd, 32'hFFFF_FF80);
    do_access(0, 1'b0, 12'h013, 32'd0, 2'd0, 1'b0, rd, e, lat);
    check("ld_byte_zext", rd, 32'h0000_0080);
    do_access(0, 1'b0, 12'h010, 32'd0, 2'd2, 1'b0, rd, e, lat);
    check("ld_word_merged", rd, 32'h80AD_BEEF);
    do_access(0, 1'b0, 12'h012, 32'd0, 2'd1, 1'b1, rd, e, lat);
    check("ld_half_hi_sext", rd, 32'hFFFF_80AD);

    do_access(0, 1'b1, 12'h022, 32'h0000_1234, 2'd1, 1'b0, rd, e, lat);
    do_access(0, 1'b0, 12'h020, 32'd0, 2'd2, 1'b0, rd, e, lat);
    check("ld_word_half_st", rd, 32'h1234_0000);
    do_access(0, 1'b0, 12'h022, 32'd0, 2'd1, 1'b1, rd, e, lat);
    check("ld_half_sext_pos", rd, 32'h0000_1234);

    do_access(0, 1'b0, 12'h011, 32'd0, 2'd2, 1'b0, rd, e, lat);
    check("mis_ld_err", e, 1'b1);
    check("mis_ld_rdata", rd, 32'd0);
    do_access(0, 1'b1, 12'h023, 32'h0000_FFFF, 2'd1, 1'b0, rd, e, lat);
    check("mis_st_err", e, 1'b1);
    do_access(0, 1'b0, 12'h000, 32'd0, 2'd3, 1'b0, rd, e, lat);
    check("rsv_size_err", e, 1'b1);
    do_access(0, 1'b1, 12'h020, 32'hFFFF_FFFF, 2'd3, 1'b0, rd, e, lat);
    check("rsv_st_err", e, 1'b1);
    do_access(0, 1'b0, 12'h020, 32'd0, 2'd2, 1'b0, rd, e, lat);
    check("ld_word_unchanged", rd, 32'h1234_0000);

    // reset during WAIT of a store
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 12'h030; wdata[0] = 32'hAAAA_AAAA; size[0] = 2'd2; req[0] = 1'b1;
    @(negedge clk);
    check("abort_busy_before", busy[0], 1'b1);
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_after", busy[0], 1'b0);
    check("abort_no_ack", ack[0], 1'b0);
    repeat (4) @(negedge clk);

    // reset exactly on the commit edge
    wr[0] = 1'b1; addr[0] = 12'h030; wdata[0] = 32'hAAAA_AAAA; size[0] = 2'd2; req[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("commit_rst_no_ack", ack[0], 1'b0);
    do_access(0, 1'b0, 12'h030, 32'd0, 2'd2, 1'b0, rd, e, lat);
    check("ld_after_abort", rd, 32'h1357_9BDF);

    // zero-wait instance with req held for four cycles
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 12'h040; wdata[1] = 32'h0000_5A5A; size[1] = 2'd2; sext[1] = 1'b0;
    req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ackbits[i]  = ack[1];
      busybits[i] = busy[1];
    end
    req[1] = 1'b0;
    check("w0_ack_pattern", ackbits, 4'b0101);
    check("w0_busy_pattern", busybits, 4'b0101);
    do_access(1, 1'b0, 12'h040, 32'd0, 2'd2, 1'b0, rd, e, lat);
    check("w0_ld_lat", lat, 32'd1);
    check("w0_ld_word", rd, 32'h0000_5A5A);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
